// File: rtl/skinny_round_ctrl_pkg.sv
// Shared definitions for the SKINNY round-control sequencer.
//   state_e  : sequencer FSM states
//   cmd_e    : host command encodings (2-bit, fully decoded)
//   tgt_e    : serial-load target register
//   RC_INIT  : round-constant LFSR value at the start of every RUN
//   RPC      : rounds unrolled per clock by the round function (not overridable)
//   rc_step  : one step of the 6-bit round-constant LFSR
package skinny_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CMD_CLR    = 2'd0,
        CMD_LOAD_S = 2'd1,  // LOAD_Y when cmd_y=1
        CMD_LOAD_X = 2'd2,
        CMD_RUN    = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        TGT_S,
        TGT_X,
        TGT_Y
    } tgt_e;

    localparam logic [5:0]  RC_INIT = 6'h00;
    localparam int unsigned RPC     = 4;

    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/skinny_round_ctrl_lfsr4.sv
// Combinational four-step round-constant generator.
//   rc      in  6  current registered round constant
//   c1..c4  out 6  constants for rounds 4k..4k+3 (one LFSR step each)
//   rc_next out 6  value to register for the next cycle (equals c4)
module skinny_rc_lfsr4
    import skinny_round_ctrl_pkg::*;
(
    input  logic [5:0] rc,
    output logic [5:0] c1,
    output logic [5:0] c2,
    output logic [5:0] c3,
    output logic [5:0] c4,
    output logic [5:0] rc_next
);

    always_comb begin
        c1      = rc_step(rc);
        c2      = rc_step(c1);
        c3      = rc_step(c2);
        c4      = rc_step(c3);
        rc_next = c4;
    end

endmodule

// File: rtl/skinny_round_ctrl.sv
// Control sequencer upstream of mode_top for SKINNY-128-384+.
// Executes CLR, 32-bit serial loads of S/X/Y, and a full ROUNDS-round
// encryption at RPC rounds per cycle.
//   clk, rst (async, active-low)
//   cmd_valid/cmd/cmd_y/cmd_ready : command handshake (accepted only in IDLE)
//   in_valid/in_ready             : per-word handshake during LOAD
//   {s,x,y,z}{rst,enc,se}, erst   : datapath register strobes
//   constant..constant4           : round constants for this cycle (0 outside RUN)
//   busy : not IDLE      done : one-cycle pulse when a RUN completes
module skinny_round_ctrl
    import skinny_round_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS = 40,
    parameter int unsigned WORDS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic       cmd_y,
    output logic       cmd_ready,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       srst,
    output logic       senc,
    output logic       sse,
    output logic       xrst,
    output logic       xenc,
    output logic       xse,
    output logic       yrst,
    output logic       yenc,
    output logic       yse,
    output logic       zrst,
    output logic       zenc,
    output logic       zse,
    output logic       erst,
    output logic [5:0] constant,
    output logic [5:0] constant2,
    output logic [5:0] constant3,
    output logic [5:0] constant4,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CYCLES = ROUNDS / RPC;
    localparam int unsigned RCW    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int unsigned WCW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e         state, state_nx;
    tgt_e           tgt;
    logic [WCW-1:0] word_cnt;
    logic [RCW-1:0] rnd_cnt;
    logic [5:0]     rc;
    logic [5:0]     c1, c2, c3, c4, rc_nx;
    logic           last_word, last_rnd;

    assign last_word = (word_cnt == WCW'(WORDS - 1));
    assign last_rnd  = (rnd_cnt == RCW'(CYCLES - 1));

    skinny_rc_lfsr4 u_lfsr (
        .rc      (rc),
        .c1      (c1),
        .c2      (c2),
        .c3      (c3),
        .c4      (c4),
        .rc_next (rc_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tgt      <= TGT_S;
            word_cnt <= '0;
            rnd_cnt  <= '0;
            rc       <= RC_INIT;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    // Target is latched on every accept; only meaningful for loads.
                    if (cmd_valid) begin
                        if (cmd == CMD_LOAD_X)
                            tgt <= TGT_X;
                        else if (cmd_y)
                            tgt <= TGT_Y;
                        else
                            tgt <= TGT_S;
                        word_cnt <= '0;
                        rnd_cnt  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid)
                        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                end
                ST_RUN: begin
                    rc      <= rc_nx;
                    rnd_cnt <= last_rnd ? '0 : rnd_cnt + 1'b1;
                end
                ST_DONE: rc <= RC_INIT;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        srst = 1'b0; senc = 1'b0; sse = 1'b0;
        xrst = 1'b0; xenc = 1'b0; xse = 1'b0;
        yrst = 1'b0; yenc = 1'b0; yse = 1'b0;
        zrst = 1'b0; zenc = 1'b0; zse = 1'b0;
        erst = 1'b0;
        constant  = '0;
        constant2 = '0;
        constant3 = '0;
        constant4 = '0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd)
                        CMD_CLR:                state_nx = ST_CLR;
                        CMD_LOAD_S, CMD_LOAD_X: state_nx = ST_LOAD;
                        default:                state_nx = ST_RUN;
                    endcase
                end
            end
            ST_CLR: begin
                srst = 1'b1; xrst = 1'b1; yrst = 1'b1; zrst = 1'b1; erst = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (tgt)
                        TGT_X:   xse = 1'b1;
                        TGT_Y:   yse = 1'b1;
                        default: sse = 1'b1;
                    endcase
                    if (last_word)
                        state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                senc = 1'b1; xenc = 1'b1; yenc = 1'b1; zenc = 1'b1;
                constant  = c1;
                constant2 = c2;
                constant3 = c3;
                constant4 = c4;
                if (last_rnd)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
